// File: rtl/bit_population_generator.sv
`default_nettype none
// ============================================================================
// Module      : bit_population_generator
// Description : Produces a WIDTH-bit word with exactly K bits set. The set
//               positions come from an LFSR-driven circular probe, so the
//               output sequence depends only on SEED and the requests seen
//               since reset. Requests with K above WIDTH/2 place the zeros
//               instead of the ones and invert the result, which keeps the
//               job at no more than WIDTH/2 placement cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_population_generator #(
  parameter int          WIDTH = 32,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [$clog2(WIDTH):0]   cnt_i,
  input  logic                     cnt_val_i,
  output logic                     cnt_ready_o,
  output logic [WIDTH-1:0]         data_o,
  output logic                     data_val_o,
  input  logic                     data_ready_i
);

  localparam int AW = $clog2(WIDTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLACE = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic              inv_q, inv_d;
  logic [WIDTH-1:0]  data_q, data_d;

  logic [CW-1:0]     k_sat;
  logic              inv_acc;
  logic [CW-1:0]     m_acc;
  logic [15:0]       lfsr_next;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     probe_pos;
  logic [AW-1:0]     sel_pos;
  logic [WIDTH-1:0]  sel_onehot;
  logic [WIDTH-1:0]  mask_set;

  // Request decode: saturate K, decide whether to place ones or zeros.
  always_comb begin
    k_sat   = (cnt_i > CW'(WIDTH)) ? CW'(WIDTH) : cnt_i;
    inv_acc = (k_sat > CW'(WIDTH / 2));
    m_acc   = inv_acc ? (CW'(WIDTH) - k_sat) : k_sat;
  end

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
  always_comb begin
    lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Circular first-free search starting at idx; the lowest offset wins
  // because it is visited last. Address arithmetic wraps naturally in AW bits.
  always_comb begin
    idx        = lfsr_q[AW-1:0];
    probe_pos  = '0;
    sel_pos    = idx;
    sel_onehot = '0;
    for (int j = WIDTH - 1; j >= 0; j--) begin
      probe_pos = idx + AW'(j);
      if (!mask_q[probe_pos]) begin
        sel_pos = probe_pos;
      end
    end
    sel_onehot[sel_pos] = 1'b1;
    mask_set            = mask_q | sel_onehot;
  end

  // Next-state logic for the IDLE -> PLACE -> OUT job sequence.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    mask_d  = mask_q;
    rem_d   = rem_q;
    inv_d   = inv_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (cnt_val_i && cnt_ready_o) begin
          inv_d  = inv_acc;
          rem_d  = m_acc;
          mask_d = '0;
          if (m_acc == '0) begin
            state_d = OUT;
            data_d  = inv_acc ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
          end else begin
            state_d = PLACE;
          end
        end
      end
      PLACE: begin
        mask_d = mask_set;
        rem_d  = rem_q - CW'(1);
        lfsr_d = lfsr_next;
        if (rem_q == CW'(1)) begin
          state_d = OUT;
          data_d  = inv_q ? ~mask_set : mask_set;
        end
      end
      OUT: begin
        if (data_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any job and reloads the LFSR seed.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      mask_q  <= '0;
      rem_q   <= '0;
      inv_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
      inv_q   <= inv_d;
      data_q  <= data_d;
    end
  end

  assign cnt_ready_o = (state_q == IDLE) && !srst_i;
  assign data_val_o  = (state_q == OUT);
  assign data_o      = data_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_population_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_population_generator
// Description : Scoreboard bench for bit_population_generator (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_population_generator;

  localparam int          WIDTH = 32;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clk_i = 1'b0;
  logic        srst_i;
  logic [5:0]  cnt_i;
  logic        cnt_val_i;
  logic        cnt_ready_o;
  logic [31:0] data_o;
  logic        data_val_o;
  logic        data_ready_i;

  typedef struct {
    logic [31:0] word;
    int          k;
    int          m;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_lfsr;
  int          checks = 0;
  int          errors = 0;

  bit_population_generator #(.WIDTH(WIDTH), .SEED(SEED)) dut (
    .clk_i       (clk_i),
    .srst_i      (srst_i),
    .cnt_i       (cnt_i),
    .cnt_val_i   (cnt_val_i),
    .cnt_ready_o (cnt_ready_o),
    .data_o      (data_o),
    .data_val_o  (data_val_o),
    .data_ready_i(data_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: probe upward from the LFSR index until a free slot is found.
  task automatic model_job(input int k, output exp_t e);
    int          kk;
    bit          inv;
    int          p;
    logic [31:0] mask;
    kk   = (k > WIDTH) ? WIDTH : k;
    inv  = (kk > WIDTH / 2);
    e.k  = kk;
    e.m  = inv ? (WIDTH - kk) : kk;
    mask = 32'h0;
    for (int n = 0; n < e.m; n++) begin
      p = int'(m_lfsr[4:0]);
      while (mask[p]) p = (p + 1) % WIDTH;
      mask[p] = 1'b1;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    e.word = inv ? ~mask : mask;
  endtask

  // One request/response; place cycles counted from the accepting edge.
  task automatic run_job(input int k, output logic [31:0] got, output int cyc);
    exp_t e;
    exp_t ex;
    int   w;
    got = 32'h0;
    cyc = 0;
    w   = 0;
    while (!cnt_ready_o && w < 50) begin
      tick();
      w++;
    end
    checks++;
    if (!cnt_ready_o) begin
      errors++;
      $display("FAIL ready_timeout k=%0d: cnt_ready_o=%0b, required 1", k, cnt_ready_o);
      return;
    end
    cnt_i     = 6'(k);
    cnt_val_i = 1'b1;
    tick();
    model_job(k, e);
    sb_q.push_back(e);
    // Noise on the request port while busy must be ignored.
    cnt_i = 6'($urandom_range(0, 63));
    while (!data_val_o && cyc < 100) begin
      tick();
      cyc++;
    end
    cnt_val_i = 1'b0;
    ex = sb_q.pop_front();
    checks++;
    if (!data_val_o) begin
      errors++;
      $display("FAIL val_timeout k=%0d: data_val_o=%0b, required 1", k, data_val_o);
      return;
    end
    got = data_o;
    checks++;
    if (data_o !== ex.word) begin
      errors++;
      $display("FAIL data k=%0d: got %h, required %h", k, data_o, ex.word);
    end
    checks++;
    if ($countones(data_o) != ex.k) begin
      errors++;
      $display("FAIL popcount k=%0d: got %0d, required %0d", k, $countones(data_o), ex.k);
    end
    checks++;
    if (cyc != ex.m) begin
      errors++;
      $display("FAIL latency k=%0d: got %0d place cycles, required %0d", k, cyc, ex.m);
    end
    data_ready_i = 1'b1;
    tick();
    data_ready_i = 1'b0;
    checks++;
    if (data_val_o !== 1'b0 || cnt_ready_o !== 1'b1 || data_o !== ex.word) begin
      errors++;
      $display("FAIL post_xfer k=%0d: val=%0b rdy=%0b data=%h, required val=0 rdy=1 data=%h",
               k, data_val_o, cnt_ready_o, data_o, ex.word);
    end
  endtask

  task automatic test_reset();
    srst_i = 1'b1;
    repeat (3) tick();
    checks++;
    if (cnt_ready_o !== 1'b0 || data_val_o !== 1'b0 || data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b val=%0b data=%h, required 0 0 00000000",
               cnt_ready_o, data_val_o, data_o);
    end
    srst_i = 1'b0;
    m_lfsr = SEED;
    #1;
    checks++;
    if (cnt_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: cnt_ready_o=%0b, required 1", cnt_ready_o);
    end
  endtask

  task automatic test_zero_and_first();
    logic [31:0] got;
    int          cyc;
    run_job(0, got, cyc);
    checks++;
    if (got !== 32'h0 || dut.lfsr_q !== SEED) begin
      errors++;
      $display("FAIL k0: data=%h lfsr=%h, required 00000000 %h", got, dut.lfsr_q, SEED);
    end
    run_job(1, got, cyc);
    checks++;
    if (got !== 32'h0000_0002 || cyc != 1) begin
      errors++;
      $display("FAIL first_k1: data=%h cyc=%0d, required 00000002 1", got, cyc);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] got;
    int          cyc;
    run_job(32, got, cyc);
    checks++;
    if (got !== 32'hFFFF_FFFF || cyc != 0) begin
      errors++;
      $display("FAIL k32: data=%h cyc=%0d, required ffffffff 0", got, cyc);
    end
    run_job(40, got, cyc);
    checks++;
    if (got !== 32'hFFFF_FFFF || cyc != 0) begin
      errors++;
      $display("FAIL k40_sat: data=%h cyc=%0d, required ffffffff 0", got, cyc);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] got;
    int          cyc;
    for (int k = 0; k <= WIDTH; k++) begin
      run_job(k, got, cyc);
      if (k == 17) begin
        checks++;
        if (cyc != 15) begin
          errors++;
          $display("FAIL k17_cycles: got %0d, required 15", cyc);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t        e;
    logic [31:0] held;
    int          cyc;
    cnt_i     = 6'd5;
    cnt_val_i = 1'b1;
    tick();
    cnt_val_i = 1'b0;
    model_job(5, e);
    sb_q.push_back(e);
    cyc = 0;
    while (!data_val_o && cyc < 100) begin
      tick();
      cyc++;
    end
    e    = sb_q.pop_front();
    held = data_o;
    checks++;
    if (data_val_o !== 1'b1 || held !== e.word) begin
      errors++;
      $display("FAIL bp_first: val=%0b data=%h, required 1 %h", data_val_o, held, e.word);
    end
    for (int i = 0; i < 10; i++) begin
      cnt_val_i = i[0];
      cnt_i     = 6'd3;
      tick();
      checks++;
      if (data_val_o !== 1'b1 || data_o !== e.word || cnt_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d: val=%0b data=%h rdy=%0b, required 1 %h 0",
                 i, data_val_o, data_o, cnt_ready_o, e.word);
      end
    end
    cnt_val_i    = 1'b0;
    data_ready_i = 1'b1;
    tick();
    data_ready_i = 1'b0;
    checks++;
    if (data_val_o !== 1'b0 || cnt_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: val=%0b rdy=%0b, required 0 1", data_val_o, cnt_ready_o);
    end
    tick();
    checks++;
    if (data_val_o !== 1'b0 || cnt_ready_o !== 1'b1 || data_o !== e.word) begin
      errors++;
      $display("FAIL bp_idle: val=%0b rdy=%0b data=%h, required 0 1 %h",
               data_val_o, cnt_ready_o, data_o, e.word);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    int          cyc;
    cnt_i     = 6'd12;
    cnt_val_i = 1'b1;
    tick();
    cnt_val_i = 1'b0;
    repeat (3) tick();
    srst_i = 1'b1;
    #1;
    checks++;
    if (cnt_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_rdy: cnt_ready_o=%0b, required 0", cnt_ready_o);
    end
    tick();
    checks++;
    if (data_val_o !== 1'b0 || data_o !== 32'h0 || cnt_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_state: val=%0b data=%h rdy=%0b, required 0 00000000 0",
               data_val_o, data_o, cnt_ready_o);
    end
    srst_i = 1'b0;
    m_lfsr = SEED;
    sb_q.delete();
    tick();
    checks++;
    if (data_val_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_noout: data_val_o=%0b, required 0", data_val_o);
    end
    run_job(1, got, cyc);
    checks++;
    if (got !== 32'h0000_0002) begin
      errors++;
      $display("FAIL mid_rst_replay: data=%h, required 00000002", got);
    end
    run_job(7, got, cyc);
    run_job(20, got, cyc);
    run_job(16, got, cyc);
  endtask

  initial begin
    srst_i       = 1'b1;
    cnt_i        = 6'd0;
    cnt_val_i    = 1'b0;
    data_ready_i = 1'b0;
    m_lfsr       = SEED;
    test_reset();
    test_zero_and_first();
    test_saturate();
    test_sweep();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
